mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL be the request address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL be the data width; the write mask width is DATA_WIDTH/8.
REQ-003 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 if_req_valid/if_req_ready  in/out  1/1  SHALL be the instruction-fetch master request handshake.
REQ-006 if_req_addr  in  ADDR_WIDTH  SHALL be the fetch address; the fetch master is read-only.
REQ-007 if_resp_valid/if_resp_ready/if_resp_rdata  out/in/out  1/1/DATA_WIDTH  SHALL be the fetch response channel.
REQ-008 ls_req_valid/ls_req_ready  in/out  1/1  SHALL be the load-store master request handshake.
REQ-009 ls_req_addr/ls_req_wen/ls_req_wdata/ls_req_wmask  in  ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH/8  SHALL be the load-store request payload.
REQ-010 ls_resp_valid/ls_resp_ready/ls_resp_rdata  out/in/out  1/1/DATA_WIDTH  SHALL be the load-store response channel.
REQ-011 mem_req_valid/mem_req_ready  out/in  1/1  SHALL be the request handshake toward the single memory slave.
REQ-012 mem_req_addr/mem_req_wen/mem_req_wdata/mem_req_wmask  out  ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH/8  SHALL be the forwarded payload.
REQ-013 mem_resp_valid/mem_resp_ready/mem_resp_rdata  in/out/in  1/1/DATA_WIDTH  SHALL be the slave response channel.

Function
REQ-014 A transfer SHALL occur on any channel in a cycle where valid and ready are both 1 at the rising edge.
REQ-015 The FSM SHALL have exactly three states: IDLE, REQ, RESP; a 1-bit owner register (IF=0, LS=1) and a 1-bit last_grant register.
REQ-016 In IDLE all req_ready, resp_valid, mem_req_valid and mem_resp_ready outputs SHALL be 0.
REQ-017 IDLE with exactly one req_valid high SHALL latch that master as owner and go to REQ next cycle.
REQ-018 IDLE with both req_valid high SHALL grant the master not equal to last_grant (round-robin).
REQ-019 Upon leaving IDLE, last_grant SHALL be loaded with the new owner.
REQ-020 In REQ, mem_req_valid SHALL equal owner req_valid, owner req_ready SHALL equal mem_req_ready, and mem payload SHALL equal owner payload combinationally.
REQ-021 When the owner is IF, mem_req_wen SHALL be 0 and mem_req_wdata/mem_req_wmask SHALL be 0.
REQ-022 In REQ, a mem request handshake SHALL move the FSM to RESP; otherwise the FSM SHALL stay in REQ (also if the owner drops req_valid).
REQ-023 In RESP, owner resp_valid SHALL equal mem_resp_valid and mem_resp_ready SHALL equal owner resp_ready; a response handshake SHALL return the FSM to IDLE.
REQ-024 Writes SHALL also complete through a response handshake; rdata is then don't-care.
REQ-025 Both if_resp_rdata and ls_resp_rdata SHALL carry mem_resp_rdata unconditionally; only the owner's resp_valid may be 1.
REQ-026 The non-owner's req_ready and resp_valid SHALL be 0 in every state.
REQ-027 At most one transaction SHALL be outstanding; minimum latency from req_valid to response handshake SHALL be 3 cycles (IDLE, REQ, RESP) with a zero-wait slave.
REQ-028 A request arriving in the same cycle the FSM returns to IDLE SHALL be arbitrated in the following IDLE cycle.

Reset
REQ-029 While reset=0, state SHALL be IDLE, owner=IF, last_grant=LS, and all handshake outputs SHALL be 0 asynchronously.
REQ-030 Reset asserted mid-transaction SHALL abandon it; no response SHALL be delivered for it after release.
REQ-031 After release, the first simultaneous request SHALL be granted to IF (since last_grant=LS).

Verification
REQ-032 IF read 0x80000000, slave ready immediately, rdata 0x00000413 -> if_req_ready high in cycle 2, if_resp_valid with 0x00000413 in cycle 3, FSM back to IDLE.
REQ-033 LS write addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF -> mem_req_wen=1 and payload forwarded exactly; ls_resp_valid asserted once.
REQ-034 Both masters request continuously from reset -> grants alternate IF, LS, IF, LS; non-owner ready/valid stay 0.
REQ-035 Slave holds mem_req_ready=0 for 5 cycles, then mem_resp_valid with owner resp_ready=0 for 3 cycles -> FSM remains in REQ then RESP; no handshake lost or duplicated.
REQ-036 Assert reset during RESP of an LS read -> all outputs 0 immediately; after release, no ls_resp_valid for the aborted read.
REQ-037 IF fetch with mem_req_wen checked every REQ cycle -> wen, wdata, wmask always 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master (instruction fetch, load-store) round-robin arbiter in front of a single memory slave.
// One transaction is outstanding at a time: arbitrate in IDLE, forward the request in REQ, return the response in RESP.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,

  // Instruction-fetch master (read-only)
  input  logic                    if_req_valid,
  output logic                    if_req_ready,
  input  logic [ADDR_WIDTH-1:0]   if_req_addr,
  output logic                    if_resp_valid,
  input  logic                    if_resp_ready,
  output logic [DATA_WIDTH-1:0]   if_resp_rdata,

  // Load-store master
  input  logic                    ls_req_valid,
  output logic                    ls_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ls_req_addr,
  input  logic                    ls_req_wen,
  input  logic [DATA_WIDTH-1:0]   ls_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] ls_req_wmask,
  output logic                    ls_resp_valid,
  input  logic                    ls_resp_ready,
  output logic [DATA_WIDTH-1:0]   ls_resp_rdata,

  // Memory slave
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic                    mem_req_wen,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wmask,
  input  logic                    mem_resp_valid,
  output logic                    mem_resp_ready,
  input  logic [DATA_WIDTH-1:0]   mem_resp_rdata
);

  localparam logic OwnerIf = 1'b0;
  localparam logic OwnerLs = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp
  } state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_grant_q, last_grant_d;

  logic   in_req;
  logic   in_resp;
  logic   owner_req_valid;
  logic   owner_resp_ready;

  assign in_req  = (state_q == StReq);
  assign in_resp = (state_q == StResp);

  assign owner_req_valid  = (owner_q == OwnerLs) ? ls_req_valid  : if_req_valid;
  assign owner_resp_ready = (owner_q == OwnerLs) ? ls_resp_ready : if_resp_ready;

  // Next-state: arbitration, request forwarding and response return
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (if_req_valid || ls_req_valid) begin
          if (if_req_valid && ls_req_valid) begin
            owner_d = ~last_grant_q;
          end else if (ls_req_valid) begin
            owner_d = OwnerLs;
          end else begin
            owner_d = OwnerIf;
          end
          last_grant_d = owner_d;
          state_d      = StReq;
        end
      end
      StReq: begin
        // Stays here even if the owner withdraws its request
        if (mem_req_valid && mem_req_ready) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (mem_resp_valid && mem_resp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= OwnerIf;
      last_grant_q <= OwnerLs;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Request channel toward the slave
  always_comb begin
    mem_req_valid = in_req & owner_req_valid;
    mem_req_addr  = (owner_q == OwnerLs) ? ls_req_addr : if_req_addr;
    mem_req_wen   = 1'b0;
    mem_req_wdata = '0;
    mem_req_wmask = '0;
    if (owner_q == OwnerLs) begin
      mem_req_wen   = ls_req_wen;
      mem_req_wdata = ls_req_wdata;
      mem_req_wmask = ls_req_wmask;
    end
  end

  // Handshake steering; the non-owner never sees ready or valid
  always_comb begin
    if_req_ready   = in_req  & (owner_q == OwnerIf) & mem_req_ready;
    ls_req_ready   = in_req  & (owner_q == OwnerLs) & mem_req_ready;
    if_resp_valid  = in_resp & (owner_q == OwnerIf) & mem_resp_valid;
    ls_resp_valid  = in_resp & (owner_q == OwnerLs) & mem_resp_valid;
    mem_resp_ready = in_resp & owner_resp_ready;
  end

  assign if_resp_rdata = mem_resp_rdata;
  assign ls_resp_rdata = mem_resp_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reset, single-master reads/writes, round-robin,
// slave back-pressure, mid-transaction reset and IF write-field suppression.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst_n;
  logic          if_req_valid, if_req_ready;
  logic [AW-1:0] if_req_addr;
  logic          if_resp_valid, if_resp_ready;
  logic [DW-1:0] if_resp_rdata;
  logic          ls_req_valid, ls_req_ready;
  logic [AW-1:0] ls_req_addr;
  logic          ls_req_wen;
  logic [DW-1:0] ls_req_wdata;
  logic [DW/8-1:0] ls_req_wmask;
  logic          ls_resp_valid, ls_resp_ready;
  logic [DW-1:0] ls_resp_rdata;
  logic          mem_req_valid, mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_wen;
  logic [DW-1:0] mem_req_wdata;
  logic [DW/8-1:0] mem_req_wmask;
  logic          mem_resp_valid, mem_resp_ready;
  logic [DW-1:0] mem_resp_rdata;

  int checks;
  int failures;

  mem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req_addr   (if_req_addr),
    .if_resp_valid (if_resp_valid),
    .if_resp_ready (if_resp_ready),
    .if_resp_rdata (if_resp_rdata),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_req_addr   (ls_req_addr),
    .ls_req_wen    (ls_req_wen),
    .ls_req_wdata  (ls_req_wdata),
    .ls_req_wmask  (ls_req_wmask),
    .ls_resp_valid (ls_resp_valid),
    .ls_resp_ready (ls_resp_ready),
    .ls_resp_rdata (ls_resp_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wmask (mem_req_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_ready(mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {if_req_ready, if_resp_valid, ls_req_ready, ls_resp_valid, mem_req_valid, mem_resp_ready}
  logic [5:0] hs;
  assign hs = {if_req_ready, if_resp_valid, ls_req_ready, ls_resp_valid,
               mem_req_valid, mem_resp_ready};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req_valid   = 1'b0;
    if_req_addr    = '0;
    if_resp_ready  = 1'b0;
    ls_req_valid   = 1'b0;
    ls_req_addr    = '0;
    ls_req_wen     = 1'b0;
    ls_req_wdata   = '0;
    ls_req_wmask   = '0;
    ls_resp_ready  = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    if_req_valid   = 1'b1;
    ls_req_valid   = 1'b1;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    if_resp_ready  = 1'b1;
    ls_resp_ready  = 1'b1;
    step();
    step();
    checks++;
    if (hs !== 6'b000000) begin
      failures++;
      $display("FAIL reset_handshakes got=%b want=%b", hs, 6'b000000);
    end
    clear_inputs();
    rst_n = 1'b1;
    #1;
    checks++;
    if (hs !== 6'b000000) begin
      failures++;
      $display("FAIL reset_idle_after_release got=%b want=%b", hs, 6'b000000);
    end
  endtask

  task automatic test_if_read();
    step();
    if_req_valid  = 1'b1;
    if_req_addr   = 32'h8000_0000;
    if_resp_ready = 1'b1;
    mem_req_ready = 1'b1;
    #1;
    checks++;
    if (hs !== 6'b000000) begin
      failures++;
      $display("FAIL if_read_idle got=%b want=%b", hs, 6'b000000);
    end
    step();
    checks++;
    if (hs !== 6'b100010) begin
      failures++;
      $display("FAIL if_read_req_hs got=%b want=%b", hs, 6'b100010);
    end
    checks++;
    if (mem_req_addr !== 32'h8000_0000 || mem_req_wen !== 1'b0) begin
      failures++;
      $display("FAIL if_read_req_payload got=%h/%b want=%h/0", mem_req_addr, mem_req_wen,
               32'h8000_0000);
    end
    step();
    if_req_valid   = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h0000_0413;
    #1;
    checks++;
    if (hs !== 6'b010001 || if_resp_rdata !== 32'h0000_0413) begin
      failures++;
      $display("FAIL if_read_resp got=%b/%h want=%b/%h", hs, if_resp_rdata, 6'b010001,
               32'h0000_0413);
    end
    step();
    mem_resp_valid = 1'b0;
    #1;
    checks++;
    if (hs !== 6'b000000) begin
      failures++;
      $display("FAIL if_read_back_idle got=%b want=%b", hs, 6'b000000);
    end
    clear_inputs();
  endtask

  task automatic test_ls_write();
    int resp_count;
    resp_count    = 0;
    ls_req_valid  = 1'b1;
    ls_req_addr   = 32'h8000_1000;
    ls_req_wen    = 1'b1;
    ls_req_wdata  = 32'hDEAD_BEEF;
    ls_req_wmask  = 4'hF;
    ls_resp_ready = 1'b1;
    mem_req_ready = 1'b1;
    #1;
    checks++;
    if (hs !== 6'b000000) begin
      failures++;
      $display("FAIL ls_write_idle got=%b want=%b", hs, 6'b000000);
    end
    step();
    checks++;
    if (hs !== 6'b001010) begin
      failures++;
      $display("FAIL ls_write_req_hs got=%b want=%b", hs, 6'b001010);
    end
    checks++;
    if (mem_req_addr !== 32'h8000_1000 || mem_req_wen !== 1'b1 ||
        mem_req_wdata !== 32'hDEAD_BEEF || mem_req_wmask !== 4'hF) begin
      failures++;
      $display("FAIL ls_write_payload got=%h/%b/%h/%h want=80001000/1/deadbeef/f",
               mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask);
    end
    step();
    ls_req_valid   = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    #1;
    if (ls_resp_valid === 1'b1) resp_count++;
    checks++;
    if (hs !== 6'b000101) begin
      failures++;
      $display("FAIL ls_write_resp_hs got=%b want=%b", hs, 6'b000101);
    end
    step();
    mem_resp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (ls_resp_valid === 1'b1) resp_count++;
      step();
    end
    checks++;
    if (resp_count !== 1) begin
      failures++;
      $display("FAIL ls_write_resp_once got=%0d want=1", resp_count);
    end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_owner;
    logic       own;
    exp_owner = 4'b1010;  // grant k is bit k: IF, LS, IF, LS
    rst_n = 1'b0;
    #1;
    clear_inputs();
    step();
    if_req_valid   = 1'b1;
    ls_req_valid   = 1'b1;
    if_resp_ready  = 1'b1;
    ls_resp_ready  = 1'b1;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h1234_5678;
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 12; k++) begin
      own = exp_owner[k/3];
      checks++;
      if (k % 3 == 0) begin
        if (hs !== 6'b000000) begin
          failures++;
          $display("FAIL rr_idle k=%0d got=%b want=%b", k, hs, 6'b000000);
        end
      end else if (k % 3 == 1) begin
        if (hs !== {~own, 1'b0, own, 1'b0, 1'b1, 1'b0}) begin
          failures++;
          $display("FAIL rr_req k=%0d got=%b want=%b", k, hs,
                   {~own, 1'b0, own, 1'b0, 1'b1, 1'b0});
        end
      end else begin
        if (hs !== {1'b0, ~own, 1'b0, own, 1'b0, 1'b1}) begin
          failures++;
          $display("FAIL rr_resp k=%0d got=%b want=%b", k, hs,
                   {1'b0, ~own, 1'b0, own, 1'b0, 1'b1});
        end
      end
      step();
    end
    clear_inputs();
    step();
  endtask

  task automatic test_stall();
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0000_0100;
    step();
    for (int i = 0; i < 5; i++) begin
      if_req_valid = (i != 2);
      #1;
      checks++;
      if (hs !== {1'b0, 1'b0, 1'b0, 1'b0, (i != 2), 1'b0}) begin
        failures++;
        $display("FAIL stall_req i=%0d got=%b want=%b", i, hs,
                 {1'b0, 1'b0, 1'b0, 1'b0, (i != 2), 1'b0});
      end
      step();
    end
    mem_req_ready = 1'b1;
    #1;
    checks++;
    if (hs !== 6'b100010) begin
      failures++;
      $display("FAIL stall_req_accept got=%b want=%b", hs, 6'b100010);
    end
    step();
    if_req_valid   = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hCAFE_0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (hs !== 6'b010000 || if_resp_rdata !== 32'hCAFE_0001) begin
        failures++;
        $display("FAIL stall_resp i=%0d got=%b/%h want=%b/%h", i, hs, if_resp_rdata,
                 6'b010000, 32'hCAFE_0001);
      end
      step();
    end
    if_resp_ready = 1'b1;
    #1;
    checks++;
    if (hs !== 6'b010001) begin
      failures++;
      $display("FAIL stall_resp_accept got=%b want=%b", hs, 6'b010001);
    end
    step();
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (hs !== 6'b000000) begin
        failures++;
        $display("FAIL stall_no_dup i=%0d got=%b want=%b", i, hs, 6'b000000);
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    int late_resp;
    late_resp     = 0;
    ls_req_valid  = 1'b1;
    ls_req_addr   = 32'h8000_2000;
    ls_resp_ready = 1'b1;
    mem_req_ready = 1'b1;
    step();
    step();
    ls_req_valid   = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    #1;
    checks++;
    if (hs !== 6'b000101) begin
      failures++;
      $display("FAIL rst_mid_in_resp got=%b want=%b", hs, 6'b000101);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (hs !== 6'b000000) begin
      failures++;
      $display("FAIL rst_mid_async got=%b want=%b", hs, 6'b000000);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (ls_resp_valid !== 1'b0 || mem_resp_ready !== 1'b0) late_resp++;
      step();
    end
    checks++;
    if (late_resp !== 0) begin
      failures++;
      $display("FAIL rst_mid_no_late_resp got=%0d want=0", late_resp);
    end
    clear_inputs();
  endtask

  task automatic test_if_wen();
    int bad;
    bad           = 0;
    ls_req_wen    = 1'b1;
    ls_req_wdata  = 32'hFFFF_FFFF;
    ls_req_wmask  = 4'hF;
    if_req_valid  = 1'b1;
    if_req_addr   = 32'h8000_0040;
    step();
    for (int i = 0; i < 4; i++) begin
      mem_req_ready = (i == 3);
      #1;
      if (mem_req_valid !== 1'b1 || mem_req_wen !== 1'b0 || mem_req_wdata !== '0 ||
          mem_req_wmask !== '0 || mem_req_addr !== 32'h8000_0040) bad++;
      step();
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL if_wen_zero bad_cycles=%0d want=0", bad);
    end
    if_req_valid   = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    if_resp_ready  = 1'b1;
    #1;
    checks++;
    if (hs !== 6'b010001) begin
      failures++;
      $display("FAIL if_wen_resp got=%b want=%b", hs, 6'b010001);
    end
    step();
    clear_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_if_read();
    test_ls_write();
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_if_wen();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
